tdm_demux_1x4: RTL and testbench
================================

# tdm_demux_1x4

Time-division 1-to-4 demultiplexer: the receiving end of a four-channel multiplexed link. It accepts a serial stream of data beats, one per slot, with a sync marker on slot 0. It routes each beat to its channel and presents all four channels together as one registered, frame-aligned word. It sits downstream of the 4:1 mux tree, which serialises four sources onto one line, and restores the parallel channels with frame-level integrity checking.

## Interface
Parameters:
- WIDTH, 1: bit width of each slot and of each channel output.

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  slot data beat.
- din_valid  input  1  din is a valid beat this cycle; when low, nothing advances.
- sync  input  1  qualified by din_valid; marks the beat as slot 0 of a frame.
- y0, y1, y2, y3  output  WIDTH each  channel outputs for slots 0..3; registered; held between frames.
- frame_valid  output  1  one-cycle pulse; y0..y3 were just updated with a complete frame.
- sel  output  2  slot index the next accepted beat will occupy (0..3).
- sync_err  output  1  one-cycle pulse on a framing violation.

## Operation
- One clock domain. Reset is synchronous and active-high.
- State machine with two states:
  - HUNT: not aligned. Beats without sync are discarded. The first beat with din_valid&&sync goes to staging slot 0; sel becomes 1; state becomes RUN.
  - RUN: aligned. Each accepted beat is written to staging[sel], then sel increments modulo 4.
- Staging registers s0..s2 hold slots 0..2. Slot 3 is not staged.
- On the slot-3 beat:
  - y0<=s0, y1<=s1, y2<=s2, y3<=din.
  - frame_valid<=1.
  - sel wraps to 0.
  - State stays RUN.
- Framing rules in RUN, evaluated only on beats with din_valid=1:
  - sync=1 with sel≠0: early sync. sync_err pulses. The partial frame is discarded and y is not updated. The beat is taken as a new slot 0 (s0<=din, sel<=1).
  - sync=0 with sel=0: missing sync. sync_err pulses. The beat is discarded. State goes to HUNT and sel stays 0.
  - sync=1 with sel=0: normal frame start.
- din_valid=0: state, sel, staging and outputs all hold. frame_valid and sync_err are 0.
- y0..y3 change only on a completed frame. A partial frame never reaches the outputs.
- Reset:
  - y0..y3=0, s0..s2=0, frame_valid=0, sync_err=0, sel=0, state HUNT.
  - Reset applies at the next edge, including mid-frame, and discards any partial frame.
- rst has priority over all other inputs on the same edge.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency: if the slot-3 beat is presented in cycle N, y0..y3 and frame_valid are visible in cycle N+1.
- frame_valid is high for exactly one cycle per completed frame.
- sync_err is visible the cycle after the offending beat, for one cycle.
- Back-to-back frames with din_valid held high give one frame_valid every 4 cycles. sel follows 1,2,3,0 after the first sync.
- Gaps (din_valid low) stretch a frame indefinitely with no timeout.
- sel reflects the current slot pointer. It equals the mux-side select for the next beat when aligned.
- A violating beat never produces frame_valid and sync_err in the same cycle.

## Test plan
- Reset then aligned frame, WIDTH=1: beats din=0,1,0,1 with sync on the first beat, din_valid high → one cycle later y0..y3=0,1,0,1, frame_valid=1 for one cycle, sync_err=0, sel=0.
- Pre-sync garbage: three beats with sync=0 after reset → no output change; sel stays 0; sync_err=0. The next synced frame 1,1,0,0 → y=1,1,0,0.
- Gapped frame: insert 2 idle cycles between each beat of frame 1,0,1,1 → outputs unchanged until the fourth beat; then y=1,0,1,1 and frame_valid pulses once.
- Early sync: after a good frame 0,1,0,1, send beats a,b then sync on the third beat, followed by 1,1,1 → sync_err pulses after the third beat; y stays 0,1,0,1. The new frame (third beat as slot 0) completes with y updated.
- Missing sync: after a good frame, send the next beat with sync=0 → sync_err pulses; state HUNT; subsequent unsynced beats are ignored until a sync arrives.
- Reset mid-frame: assert rst after 2 beats → y0..y3=0, sel=0, frame_valid=0. The following full synced frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux_1x4.sv
// Receiving end of a four-slot TDM link: aligns on the slot-0 sync marker,
// stages slots 0..2 and publishes all four channels as one registered frame.
module tdm_demux_1x4 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    output logic [1:0]       sel,
    output logic             sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] s0, s1, s2;
    logic [WIDTH-1:0] s0_nxt, s1_nxt, s2_nxt;
    logic [WIDTH-1:0] y0_nxt, y1_nxt, y2_nxt, y3_nxt;
    logic [1:0]       sel_nxt;
    logic             frame_valid_nxt;
    logic             sync_err_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Alignment: a sync beat locks us, a missing sync on slot 0 drops lock
    always_comb begin
        state_nxt = state;
        if (din_valid) begin
            case (state)
                HUNT: if (sync) state_nxt = RUN;
                RUN:  if (!sync && (sel == 2'd0)) state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Next values for staging, slot pointer and the registered outputs
    always_comb begin
        s0_nxt          = s0;
        s1_nxt          = s1;
        s2_nxt          = s2;
        y0_nxt          = y0;
        y1_nxt          = y1;
        y2_nxt          = y2;
        y3_nxt          = y3;
        sel_nxt         = sel;
        frame_valid_nxt = 1'b0;
        sync_err_nxt    = 1'b0;
        if (din_valid) begin
            if (state == HUNT) begin
                if (sync) begin
                    s0_nxt  = din;
                    sel_nxt = 2'd1;
                end
            end else if (sync) begin
                // Sync always restarts the frame; mid-frame it also flags an error
                sync_err_nxt = (sel != 2'd0);
                s0_nxt       = din;
                sel_nxt      = 2'd1;
            end else if (sel == 2'd0) begin
                // Slot 0 without sync: discard beat, fall back to hunting
                sync_err_nxt = 1'b1;
            end else begin
                case (sel)
                    2'd1: begin
                        s1_nxt  = din;
                        sel_nxt = 2'd2;
                    end
                    2'd2: begin
                        s2_nxt  = din;
                        sel_nxt = 2'd3;
                    end
                    2'd3: begin
                        y0_nxt          = s0;
                        y1_nxt          = s1;
                        y2_nxt          = s2;
                        y3_nxt          = din;
                        frame_valid_nxt = 1'b1;
                        sel_nxt         = 2'd0;
                    end
                    default: sel_nxt = 2'd0;
                endcase
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s0          <= '0;
            s1          <= '0;
            s2          <= '0;
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            sel         <= 2'd0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            s0          <= s0_nxt;
            s1          <= s1_nxt;
            s2          <= s2_nxt;
            y0          <= y0_nxt;
            y1          <= y1_nxt;
            y2          <= y2_nxt;
            y3          <= y3_nxt;
            sel         <= sel_nxt;
            frame_valid <= frame_valid_nxt;
            sync_err    <= sync_err_nxt;
        end
    end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4: frame-level reference model, per-cycle compare,
// directed framing scenarios with literal expectations, then random traffic.
module tb_tdm_demux_1x4;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         sync;
    logic [W-1:0] y0, y1, y2, y3;
    logic         frame_valid;
    logic [1:0]   sel;
    logic         sync_err;

    int checks = 0;
    int errors = 0;

    tdm_demux_1x4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .frame_valid (frame_valid),
        .sel         (sel),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    // Reference model: collect the beats of the current frame in a queue
    logic [W-1:0] m_y [4];
    logic [W-1:0] part [$];
    bit           aligned = 1'b0;
    bit           m_fv    = 1'b0;
    bit           m_err   = 1'b0;
    bit           started = 1'b0;

    always @(posedge clk) begin
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            aligned = 1'b0;
            part.delete();
            for (int i = 0; i < 4; i++) m_y[i] = '0;
            started = 1'b1;
        end else if (din_valid) begin
            if (!aligned) begin
                if (sync) begin
                    aligned = 1'b1;
                    part.delete();
                    part.push_back(din);
                end
            end else if (sync) begin
                if (part.size() != 0) m_err = 1'b1;
                part.delete();
                part.push_back(din);
            end else if (part.size() == 0) begin
                m_err   = 1'b1;
                aligned = 1'b0;
            end else begin
                part.push_back(din);
                if (part.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_y[i] = part[i];
                    m_fv = 1'b1;
                    part.delete();
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if ({y0, y1, y2, y3} !== {m_y[0], m_y[1], m_y[2], m_y[3]}) begin
                errors++;
                $display("FAIL cmp_y t=%0t got %h%h%h%h exp %h%h%h%h", $time,
                         y0, y1, y2, y3, m_y[0], m_y[1], m_y[2], m_y[3]);
            end
            checks++;
            if (frame_valid !== m_fv) begin
                errors++;
                $display("FAIL cmp_frame_valid t=%0t got %b exp %b", $time, frame_valid, m_fv);
            end
            checks++;
            if (sync_err !== m_err) begin
                errors++;
                $display("FAIL cmp_sync_err t=%0t got %b exp %b", $time, sync_err, m_err);
            end
            checks++;
            if (sel !== 2'(part.size())) begin
                errors++;
                $display("FAIL cmp_sel t=%0t got %0d exp %0d", $time, sel, part.size());
            end
        end
    end

    task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic beat(input logic [W-1:0] d, input logic s);
        @(negedge clk);
        rst       = 1'b0;
        din_valid = 1'b1;
        sync      = s;
        din       = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = 1'b0;
            din_valid = 1'b0;
            sync      = 1'b0;
            din       = W'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b1;
        sync      = 1'b1;
        din       = 4'hF;
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        sync      = 1'b0;
        din       = '0;
        idle(1);
        pin("reset_y", 32'({y0, y1, y2, y3}), 32'h0);
        pin("reset_sel", 32'(sel), 32'd0);

        // Aligned frame 0,1,0,1
        beat(4'd0, 1'b1); beat(4'd1, 1'b0); beat(4'd0, 1'b0); beat(4'd1, 1'b0);
        idle(1);
        pin("frame1_y", 32'({y0, y1, y2, y3}), 32'h0101);
        pin("frame1_fv", 32'(frame_valid), 32'd1);
        pin("frame1_sel", 32'(sel), 32'd0);
        idle(1);
        pin("frame1_fv_once", 32'(frame_valid), 32'd0);

        // Pre-sync garbage after reset, then 1,1,0,0
        do_reset();
        beat(4'd7, 1'b0); beat(4'd6, 1'b0); beat(4'd5, 1'b0);
        idle(1);
        pin("garbage_sel", 32'(sel), 32'd0);
        pin("garbage_err", 32'(sync_err), 32'd0);
        beat(4'd1, 1'b1); beat(4'd1, 1'b0); beat(4'd0, 1'b0); beat(4'd0, 1'b0);
        idle(1);
        pin("frame2_y", 32'({y0, y1, y2, y3}), 32'h1100);

        // Gapped frame 1,0,1,1
        beat(4'd1, 1'b1); idle(2); beat(4'd0, 1'b0); idle(2); beat(4'd1, 1'b0); idle(2);
        pin("gap_hold_y", 32'({y0, y1, y2, y3}), 32'h1100);
        pin("gap_sel", 32'(sel), 32'd3);
        beat(4'd1, 1'b0);
        idle(1);
        pin("gap_y", 32'({y0, y1, y2, y3}), 32'h1011);
        pin("gap_fv", 32'(frame_valid), 32'd1);

        // Early sync on third beat
        beat(4'd0, 1'b1); beat(4'd1, 1'b0); beat(4'd0, 1'b0); beat(4'd1, 1'b0);
        beat(4'd3, 1'b1); beat(4'd7, 1'b0); beat(4'd5, 1'b1);
        idle(1);
        pin("early_err", 32'(sync_err), 32'd1);
        pin("early_fv", 32'(frame_valid), 32'd0);
        pin("early_hold_y", 32'({y0, y1, y2, y3}), 32'h0101);
        beat(4'd1, 1'b0); beat(4'd1, 1'b0); beat(4'd1, 1'b0);
        idle(1);
        pin("early_new_y", 32'({y0, y1, y2, y3}), 32'h5111);

        // Missing sync drops to hunting
        beat(4'd2, 1'b1); beat(4'd3, 1'b0); beat(4'd4, 1'b0); beat(4'd5, 1'b0);
        beat(4'd9, 1'b0);
        idle(1);
        pin("miss_err", 32'(sync_err), 32'd1);
        beat(4'd6, 1'b0); beat(4'd6, 1'b0); beat(4'd6, 1'b0); beat(4'd6, 1'b0);
        idle(1);
        pin("miss_hunt_y", 32'({y0, y1, y2, y3}), 32'h2345);
        pin("miss_hunt_sel", 32'(sel), 32'd0);

        // Reset mid-frame
        beat(4'd1, 1'b1); beat(4'd2, 1'b0);
        do_reset();
        idle(1);
        pin("rst_mid_y", 32'({y0, y1, y2, y3}), 32'h0);
        pin("rst_mid_sel", 32'(sel), 32'd0);
        beat(4'd8, 1'b1); beat(4'd9, 1'b0); beat(4'hA, 1'b0); beat(4'hB, 1'b0);
        idle(1);
        pin("rst_after_y", 32'({y0, y1, y2, y3}), 32'h89AB);

        // Random traffic, biased towards mostly well-formed framing
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 299) == 0);
            din_valid = ($urandom_range(0, 9) < 7);
            din       = W'($urandom);
            if (part.size() == 0)
                sync = ($urandom_range(0, 19) != 0);
            else
                sync = ($urandom_range(0, 29) == 0);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
